// File: rtl/alu_exec_stage.sv
`default_nettype none
// =====================================================================
// alu_exec_stage : operand select/forward, ALU drive, registered result
// Rev 1.0
// =====================================================================
module alu_exec_stage #(
   parameter int         DIV_LAT = 4,
   parameter int         REG_AW  = 5,
   parameter logic [3:0] ALU_DIV = 4'd8,
   parameter logic [3:0] ALU_MOD = 4'd9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [REG_AW-1:0] in_rs1_idx,
   input  logic [REG_AW-1:0] in_rs2_idx,
   input  logic [31:0]       in_rs1_val,
   input  logic [31:0]       in_rs2_val,
   input  logic [31:0]       in_imm,
   input  logic              in_use_imm,
   input  logic [REG_AW-1:0] in_rd,
   input  logic              in_we,
   output logic [31:0]       alu_a,
   output logic [31:0]       alu_b,
   output logic [3:0]        alu_op,
   input  logic [31:0]       alu_y,
   input  logic              alu_zero,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_y,
   output logic              out_zero,
   output logic [REG_AW-1:0] out_rd,
   output logic              out_we,
   output logic              out_divz
);

   localparam int CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
   localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(DIV_LAT - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [31:0]       r_a;
   logic [31:0]       r_b;
   logic [3:0]        r_op;
   logic [REG_AW-1:0] r_rd;
   logic              r_we;

   logic        w_out_free;
   logic        w_accept;
   logic        w_capture;
   logic        w_fwd_a;
   logic        w_fwd_b;
   logic [31:0] w_a_sel;
   logic [31:0] w_b_sel;
   logic        w_in_div;
   logic        w_q_div;

   assign w_out_free = !out_valid || out_ready;
   assign in_ready   = (r_state == ST_IDLE) && w_out_free;
   assign w_accept   = in_valid && in_ready;

   // Only the held result can be forwarded; x0 is hardwired and never forwards.
   assign w_fwd_a = out_valid && out_we && (out_rd == in_rs1_idx) && (out_rd != '0);
   assign w_fwd_b = out_valid && out_we && (out_rd == in_rs2_idx) && (out_rd != '0);
   assign w_a_sel = w_fwd_a ? out_y : in_rs1_val;
   assign w_b_sel = in_use_imm ? in_imm : (w_fwd_b ? out_y : in_rs2_val);

   assign w_in_div = (in_op == ALU_DIV) || (in_op == ALU_MOD);
   assign w_q_div  = (r_op == ALU_DIV) || (r_op == ALU_MOD);

   assign w_capture = w_out_free &&
                      ((r_state == ST_EXEC) || ((r_state == ST_WAIT) && (r_cnt == '0)));

   assign alu_a  = r_a;
   assign alu_b  = r_b;
   assign alu_op = r_op;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= '0;
         r_rd    <= '0;
         r_we    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_a     <= w_a_sel;
                  r_b     <= w_b_sel;
                  r_op    <= in_op;
                  r_rd    <= in_rd;
                  r_we    <= in_we;
                  r_state <= w_in_div ? ST_WAIT : ST_EXEC;
                  r_cnt   <= w_in_div ? C_CNT_INIT : '0;
               end
            end
            ST_EXEC: begin
               if (w_out_free) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end else if (w_out_free) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // A capture and a consume on the same edge leave out_valid set with the new result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_y     <= '0;
         out_zero  <= 1'b0;
         out_rd    <= '0;
         out_we    <= 1'b0;
         out_divz  <= 1'b0;
      end else if (w_capture) begin
         out_valid <= 1'b1;
         out_y     <= alu_y;
         out_zero  <= alu_zero;
         out_rd    <= r_rd;
         out_we    <= r_we;
         out_divz  <= w_q_div && (r_b == '0);
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// Bench for alu_exec_stage: directed scenarios plus randomized traffic
// checked against a latency/occupancy-level reference model.
module tb_alu_exec_stage;

   localparam int         DIV_LAT = 4;
   localparam int         REG_AW  = 5;
   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_DIV  = 4'd8;
   localparam logic [3:0] OP_MOD  = 4'd9;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [3:0]        in_op = '0;
   logic [REG_AW-1:0] in_rs1_idx = '0;
   logic [REG_AW-1:0] in_rs2_idx = '0;
   logic [31:0]       in_rs1_val = '0;
   logic [31:0]       in_rs2_val = '0;
   logic [31:0]       in_imm = '0;
   logic              in_use_imm = 1'b0;
   logic [REG_AW-1:0] in_rd = '0;
   logic              in_we = 1'b0;
   logic [31:0]       alu_a;
   logic [31:0]       alu_b;
   logic [3:0]        alu_op;
   logic [31:0]       alu_y;
   logic              alu_zero;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [31:0]       out_y;
   logic              out_zero;
   logic [REG_AW-1:0] out_rd;
   logic              out_we;
   logic              out_divz;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_exec_stage #(
      .DIV_LAT (DIV_LAT),
      .REG_AW  (REG_AW),
      .ALU_DIV (OP_DIV),
      .ALU_MOD (OP_MOD)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_rs1_idx (in_rs1_idx),
      .in_rs2_idx (in_rs2_idx),
      .in_rs1_val (in_rs1_val),
      .in_rs2_val (in_rs2_val),
      .in_imm     (in_imm),
      .in_use_imm (in_use_imm),
      .in_rd      (in_rd),
      .in_we      (in_we),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_y      (alu_y),
      .alu_zero   (alu_zero),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_y      (out_y),
      .out_zero   (out_zero),
      .out_rd     (out_rd),
      .out_we     (out_we),
      .out_divz   (out_divz)
   );

   function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd8:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         4'd9:    return (b == 32'd0) ? a : a % b;
         default: return a ^ {b[15:0], b[31:16]};
      endcase
   endfunction

   assign alu_y    = alu_fn(alu_op, alu_a, alu_b);
   assign alu_zero = (alu_y == 32'd0);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference: one op in flight, a single held result, capture allowed lat edges after accept.
   bit                m_ov, m_busy, m_zero, m_we, m_divz;
   logic [31:0]       m_y;
   logic [REG_AW-1:0] m_rd;
   bit                p_zero, p_we, p_divz;
   logic [31:0]       p_y;
   logic [REG_AW-1:0] p_rd;
   int                m_due = 0;
   int                cyc_n = 0;
   bit                rnd_ready = 1'b0;

   task automatic model_reset();
      m_ov = 0; m_busy = 0; m_zero = 0; m_we = 0; m_divz = 0; m_y = '0; m_rd = '0;
   endtask

   task automatic cycle(output bit acc);
      bit          free, erdy, macc, cap, fa, fb, isd;
      logic [31:0] ea, eb, ny;
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      free = !m_ov || out_ready;
      erdy = !m_busy && free;
      check("in_ready", 32'(in_ready), 32'(erdy));
      acc  = in_valid && in_ready;
      macc = in_valid && erdy;
      cap  = m_busy && (cyc_n >= m_due) && free;
      fa = m_ov && m_we && (m_rd == in_rs1_idx) && (in_rs1_idx != '0);
      fb = m_ov && m_we && (m_rd == in_rs2_idx) && (in_rs2_idx != '0);
      ea = fa ? m_y : in_rs1_val;
      eb = in_use_imm ? in_imm : (fb ? m_y : in_rs2_val);
      isd = (in_op == OP_DIV) || (in_op == OP_MOD);
      ny = alu_fn(in_op, ea, eb);
      if (cap) begin
         m_ov = 1; m_y = p_y; m_zero = p_zero; m_rd = p_rd; m_we = p_we; m_divz = p_divz;
         m_busy = 0;
      end else if (m_ov && out_ready) begin
         m_ov = 0;
      end
      if (macc) begin
         p_y = ny; p_zero = (ny == 32'd0); p_rd = in_rd; p_we = in_we;
         p_divz = isd && (eb == 32'd0);
         m_busy = 1;
         m_due  = cyc_n + (isd ? DIV_LAT : 1);
      end
      @(posedge clk);
      cyc_n++;
      #1;
      check("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
         check("out_y", out_y, m_y);
         check("out_zero", 32'(out_zero), 32'(m_zero));
         check("out_rd", 32'(out_rd), 32'(m_rd));
         check("out_we", 32'(out_we), 32'(m_we));
         check("out_divz", 32'(out_divz), 32'(m_divz));
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [REG_AW-1:0] r1i,
                        input logic [31:0] r1v, input logic [REG_AW-1:0] r2i,
                        input logic [31:0] r2v, input logic [31:0] imm, input bit ui,
                        input logic [REG_AW-1:0] rd, input bit we);
      bit acc = 1'b0;
      in_op = op; in_rs1_idx = r1i; in_rs1_val = r1v; in_rs2_idx = r2i; in_rs2_val = r2v;
      in_imm = imm; in_use_imm = ui; in_rd = rd; in_we = we; in_valid = 1'b1;
      for (int k = 0; k < 60 && !acc; k++) cycle(acc);
      if (!acc) check("issue_timeout", 32'(acc), 32'd1);
      in_valid   = 1'b0;
      in_op      = 4'($urandom);
      in_rs1_val = $urandom;
      in_rs2_val = $urandom;
      in_rs1_idx = REG_AW'($urandom);
      in_rd      = REG_AW'($urandom);
   endtask

   task automatic wait_out(output int n);
      bit acc;
      n = 0;
      do begin
         cycle(acc);
         n++;
      end while (!out_valid && n < 30);
      if (!out_valid) check("wait_timeout", 32'(out_valid), 32'd1);
   endtask

   function automatic logic [31:0] rnd_val();
      return ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
   endfunction

   initial begin
      int  n;
      bit  acc;
      logic [3:0] op;
      model_reset();
      #3;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_y", out_y, 32'd0);
      check("rst_out_rd", 32'(out_rd), 32'd0);
      check("rst_flags", {28'd0, out_zero, out_we, out_divz, 1'b0}, 32'd0);
      check("rst_alu_a", alu_a, 32'd0);
      check("rst_alu_op", 32'(alu_op), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      #19 rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic ADD latency and result.
      out_ready = 1'b1;
      issue(OP_ADD, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 1'b0, 5'd9, 1'b1);
      wait_out(n);
      check("add_lat", 32'(n), 32'd1);
      check("add_y", out_y, 32'd12);
      check("add_rd", 32'(out_rd), 32'd9);

      // Forwarding from the held result, then rd=0 which must not forward.
      issue(OP_ADD, 5'd1, 32'd4, 5'd2, 32'd6, 32'd0, 1'b0, 5'd3, 1'b1);
      wait_out(n);
      issue(OP_SUB, 5'd3, 32'd99, 5'd5, 32'd4, 32'd0, 1'b0, 5'd6, 1'b1);
      wait_out(n);
      check("fwd_y", out_y, 32'd6);
      issue(OP_ADD, 5'd1, 32'd4, 5'd2, 32'd6, 32'd0, 1'b0, 5'd0, 1'b1);
      wait_out(n);
      issue(OP_SUB, 5'd0, 32'd99, 5'd5, 32'd4, 32'd0, 1'b0, 5'd6, 1'b1);
      wait_out(n);
      check("nofwd_y", out_y, 32'd95);

      // DIV / MOD settle window.
      issue(OP_DIV, 5'd0, 32'd100, 5'd0, 32'd0, 32'd7, 1'b1, 5'd4, 1'b1);
      wait_out(n);
      check("div_lat", 32'(n), 32'(DIV_LAT));
      check("div_y", out_y, 32'd14);
      check("div_divz", 32'(out_divz), 32'd0);
      issue(OP_MOD, 5'd0, 32'd100, 5'd0, 32'd0, 32'd7, 1'b1, 5'd4, 1'b1);
      wait_out(n);
      check("mod_y", out_y, 32'd2);

      // Divide by zero flag, cleared by the next ordinary op.
      issue(OP_DIV, 5'd0, 32'd9, 5'd0, 32'd0, 32'd0, 1'b1, 5'd4, 1'b1);
      wait_out(n);
      check("divz_flag", 32'(out_divz), 32'd1);
      check("divz_zero", 32'(out_zero), 32'd0);
      issue(OP_ADD, 5'd0, 32'd1, 5'd0, 32'd1, 32'd0, 1'b0, 5'd4, 1'b1);
      wait_out(n);
      check("divz_clear", 32'(out_divz), 32'd0);

      // Writeback stall: result held, next op blocked until out_ready returns.
      issue(OP_ADD, 5'd0, 32'd1, 5'd0, 32'd2, 32'd0, 1'b0, 5'd2, 1'b1);
      out_ready = 1'b0;
      wait_out(n);
      in_op = OP_ADD; in_rs1_idx = 5'd2; in_rs1_val = 32'd77; in_rs2_idx = 5'd0;
      in_rs2_val = 32'd5; in_use_imm = 1'b0; in_rd = 5'd7; in_we = 1'b1; in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         cycle(acc);
         check("stall_acc", 32'(acc), 32'd0);
         check("stall_y", out_y, 32'd3);
      end
      out_ready = 1'b1;
      cycle(acc);
      check("release_acc", 32'(acc), 32'd1);
      in_valid = 1'b0;
      wait_out(n);
      check("release_fwd_y", out_y, 32'd8);

      // Asynchronous reset in the middle of a DIV.
      issue(OP_DIV, 5'd0, 32'd100, 5'd0, 32'd0, 32'd7, 1'b1, 5'd4, 1'b1);
      cycle(acc);
      cycle(acc);
      #1 rst_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_in_ready", 32'(in_ready), 32'd1);
      check("arst_alu_op", 32'(alu_op), 32'd0);
      rst_n = 1'b1;
      model_reset();
      for (int k = 0; k < 6; k++) cycle(acc);
      issue(OP_ADD, 5'd0, 32'd20, 5'd0, 32'd22, 32'd0, 1'b0, 5'd1, 1'b1);
      wait_out(n);
      check("post_rst_y", out_y, 32'd42);

      // Randomized traffic with random writeback back-pressure.
      rnd_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         n = $urandom_range(0, 2);
         for (int k = 0; k < n; k++) cycle(acc);
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: op = 4'($urandom_range(0, 4));
            5:             op = OP_DIV;
            6:             op = OP_MOD;
            default:       op = 4'($urandom);
         endcase
         issue(op, REG_AW'($urandom_range(0, 7)), rnd_val(), REG_AW'($urandom_range(0, 7)),
               rnd_val(), ($urandom_range(0, 4) == 0) ? 32'd0 : rnd_val(),
               1'($urandom_range(0, 1)), REG_AW'($urandom_range(0, 7)),
               1'($urandom_range(0, 3) != 0));
      end
      rnd_ready = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 20; k++) cycle(acc);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
